aximm_window_ctrl: RTL and testbench
====================================

// Module: aximm_window_ctrl
// PURPOSE: AXI4-Lite-programmed controller for the BAR1 sliding window. Stages a new window base, holds
//   new window-bound AW/AR requests, drains outstanding bursts, then swaps window_addr atomically.
// PARAMETERS
//   AW        64  width of window_addr / staged base
//   ALIGN     12  low ALIGN bits of window_addr forced to 0 (4 KiB window granularity)
//   MAX_OUT   32  max outstanding bursts per direction; counters are clog2(MAX_OUT+1) bits
// PORTS
//   clk            in   1   clock for all logic
//   reset          in   1   asynchronous, active-high reset
//   S_AXI_AWADDR   in   4   AXI4-Lite write address (byte address, bits[1:0] ignored)
//   S_AXI_AWVALID  in   1   / S_AXI_AWREADY out 1: AW handshake
//   S_AXI_WDATA    in   32  write data
//   S_AXI_WSTRB    in   4   byte strobes
//   S_AXI_WVALID   in   1   / S_AXI_WREADY out 1: W handshake
//   S_AXI_BRESP    out  2   00 OKAY, 10 SLVERR
//   S_AXI_BVALID   out  1   / S_AXI_BREADY in 1: B handshake
//   S_AXI_ARADDR   in   4   read address
//   S_AXI_ARVALID  in   1   / S_AXI_ARREADY out 1: AR handshake
//   S_AXI_RDATA    out  32  read data
//   S_AXI_RRESP    out  2   00 OKAY always
//   S_AXI_RVALID   out  1   / S_AXI_RREADY in 1: R handshake
//   window_addr    out  AW  live window base driven to the window remapper
//   window_hold    out  1   1 = upstream must not issue new window-bound AW/AR
//   mon_aw         in   1   pulse: window-bound AW handshake completed
//   mon_b          in   1   pulse: B handshake for a window-bound write
//   mon_ar         in   1   pulse: window-bound AR handshake completed
//   mon_rlast      in   1   pulse: RLAST beat handshake for a window-bound read
// BEHAVIOUR
// - Reset: window_addr=0, staged=0, hold=0, counters=0, all S_AXI valid/ready=0, B/RRESP=0, state IDLE.
// - Registers: 0x0 STAGE_LO, 0x4 STAGE_HI (R/W, WSTRB honoured; bits below ALIGN read back 0);
//   0x8 CTRL W: bit0=1 commits; 0xC STATUS R: [0]busy [1]timeout_err [15:8]wr_out [23:16]rd_out.
// - AXI-Lite write: accept AW and W independently (ready high when not holding one); once both held, do
//   update and raise BVALID next cycle; hold BVALID until BREADY. One write in flight. Read: ARREADY when
//   !RVALID; RDATA/RVALID registered 1 cycle after AR handshake, held until RREADY.
// - Writes to STAGE_* or CTRL while busy: ignored, BRESP=SLVERR. Unmapped addrs read 0 / write OKAY.
// - Counters: wr_out +mon_aw -mon_b; rd_out +mon_ar -mon_rlast; simultaneous inc+dec = unchanged.
//   Increment at MAX_OUT saturates; decrement at 0 stays 0 (protocol error, not flagged).
// - FSM IDLE -> (CTRL commit) DRAIN: hold=1 from the cycle after commit BVALID rises.
//   DRAIN -> SWAP when wr_out==0 && rd_out==0 (same cycle as mon pulses counted: use next-state values).
//   SWAP (1 cycle): window_addr <= staged; hold stays 1. SWAP -> IDLE; hold=0 next cycle.
//   busy = (state != IDLE). Commit with counters already 0: window_addr updates 2 cycles after commit B.
// - mon_aw/mon_ar asserted during hold are still counted (request already past the gate).
// - Reset mid-DRAIN/SWAP: returns to IDLE; window_addr=0; staged value lost.
// CONFIGURATION
// - WINDOW_TIMEOUT_EN defined: DRAIN longer than 65535 cycles -> abort to IDLE, window_addr unchanged,
//   STATUS[1] sticky set, cleared by writing CTRL bit1=1. Undefined: DRAIN waits forever; STATUS[1] reads 0.
// TESTING
// - Reset, write STAGE_LO=0x1234_5678, STAGE_HI=0x10 -> reads 0x1234_5000 / 0x10; window_addr=0.
// - Commit, no traffic -> hold 1 for 2 cycles, window_addr=0x10_1234_5000, STATUS busy back to 0.
// - 3 mon_aw + 2 mon_ar, commit -> hold stays 1 until 3 mon_b + 2 mon_rlast; swap 1 cycle after last.
// - Write STAGE_LO during DRAIN -> BRESP=SLVERR, staged unchanged; mon_aw+mon_b same cycle -> wr_out same.
// - WINDOW_TIMEOUT_EN: 1 mon_aw, no mon_b, commit -> after 65535 cycles IDLE, STATUS[1]=1, addr unchanged.

Source files
------------

// File: rtl/aximm_window_ctrl.sv
`timescale 1ns/1ps
// aximm_window_ctrl: AXI4-Lite programmed controller for the BAR1 sliding window.
// Software stages a new window base, then commits it. The controller raises
// window_hold so no new window-bound requests are issued, waits for all
// outstanding window-bound bursts to drain, then swaps window_addr in one cycle.
// Optional build macro: WINDOW_TIMEOUT_EN aborts a drain that exceeds 65535
// cycles and records a sticky timeout flag in STATUS[1].
module aximm_window_ctrl #(
    parameter int AW      = 64,
    parameter int ALIGN   = 12,
    parameter int MAX_OUT = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    S_AXI_AWADDR,
    input  logic          S_AXI_AWVALID,
    output logic          S_AXI_AWREADY,
    input  logic [31:0]   S_AXI_WDATA,
    input  logic [3:0]    S_AXI_WSTRB,
    input  logic          S_AXI_WVALID,
    output logic          S_AXI_WREADY,
    output logic [1:0]    S_AXI_BRESP,
    output logic          S_AXI_BVALID,
    input  logic          S_AXI_BREADY,
    input  logic [3:0]    S_AXI_ARADDR,
    input  logic          S_AXI_ARVALID,
    output logic          S_AXI_ARREADY,
    output logic [31:0]   S_AXI_RDATA,
    output logic [1:0]    S_AXI_RRESP,
    output logic          S_AXI_RVALID,
    input  logic          S_AXI_RREADY,
    output logic [AW-1:0] window_addr,
    output logic          window_hold,
    input  logic          mon_aw,
    input  logic          mon_b,
    input  logic          mon_ar,
    input  logic          mon_rlast
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWAP  = 2'd2;

    localparam logic [1:0] REG_STAGE_LO = 2'd0;
    localparam logic [1:0] REG_STAGE_HI = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bits of the 64-bit staging register that actually exist: above the
    // window granularity and below the window address width.
    function automatic logic [63:0] mask_range(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= lo && i < hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [63:0] STAGE_MASK = mask_range(ALIGN, AW);

    // Saturating up/down count; a simultaneous increment and decrement cancel.
    function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cnt,
                                                 input logic inc, input logic dec);
        logic [CW-1:0] r;
        r = cnt;
        if (inc && !dec && cnt != CNT_MAX) r = cnt + CW'(1);
        else if (dec && !inc && cnt != '0) r = cnt - CW'(1);
        return r;
    endfunction

    // Write channel state
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [1:0]    awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    // Read channel state
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    // Window control state
    logic [63:0]   staged_q, staged_d;
    logic [AW-1:0] window_q, window_d;
    logic          hold_q, hold_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] wr_out_q, wr_out_d;
    logic [CW-1:0] rd_out_q, rd_out_d;

    logic          aw_hs, w_hs, ar_hs, wr_go, busy, commit, timeout_err;
    logic [31:0]   status;
    logic          unused_addr_bits;

`ifdef WINDOW_TIMEOUT_EN
    logic [15:0]   drain_cnt_q, drain_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic          clr_err;
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;
    assign wr_go = aw_held_q && w_held_q;
    assign busy  = (state_q != ST_IDLE);

    // Byte-lane offsets are meaningless on a 32-bit register file.
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // STATUS register image
    always_comb begin
        status        = '0;
        status[0]     = busy;
        status[1]     = timeout_err;
        status[15:8]  = 8'(wr_out_q);
        status[23:16] = 8'(rd_out_q);
    end

    // Write channel: collect AW and W independently, then perform one register update
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        staged_d  = staged_q;
        commit    = 1'b0;
`ifdef WINDOW_TIMEOUT_EN
        clr_err   = 1'b0;
`endif
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (wr_go) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            case (awaddr_q)
                REG_STAGE_LO, REG_STAGE_HI: begin
                    // The staged base must not move under an in-progress swap.
                    if (busy) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) begin
                                if (awaddr_q == REG_STAGE_LO) staged_d[8*b +: 8] = wdata_q[8*b +: 8];
                                else                          staged_d[32 + 8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                        staged_d = staged_d & STAGE_MASK;
                    end
                end
                REG_CTRL: begin
                    if (busy) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        commit = wdata_q[0];
`ifdef WINDOW_TIMEOUT_EN
                        clr_err = wdata_q[1];
`endif
                    end
                end
                default: ;
            endcase
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        // Only one write in flight: stop accepting while a half is held or B is pending.
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    // Read channel: registered response one cycle after the AR handshake
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (S_AXI_ARADDR[3:2])
                REG_STAGE_LO: rdata_d = staged_q[31:0];
                REG_STAGE_HI: rdata_d = staged_q[63:32];
                REG_STATUS:   rdata_d = status;
                default:      rdata_d = '0;
            endcase
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    // Outstanding-burst counters and the commit / drain / swap sequencer
    always_comb begin
        wr_out_d = count_next(wr_out_q, mon_aw, mon_b);
        rd_out_d = count_next(rd_out_q, mon_ar, mon_rlast);
        state_d  = state_q;
        window_d = window_q;
`ifdef WINDOW_TIMEOUT_EN
        drain_cnt_d   = '0;
        timeout_err_d = timeout_err_q;
        if (clr_err) timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (commit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Use the post-update counts so a final pulse this cycle is seen immediately.
                if (wr_out_d == '0 && rd_out_d == '0) begin
                    state_d = ST_SWAP;
`ifdef WINDOW_TIMEOUT_EN
                end else if (drain_cnt_q == 16'hFFFF) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
`endif
                end
            end
            ST_SWAP: begin
                window_d = staged_q[AW-1:0];
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Hold lags the state by one cycle so it covers the cycle the new base goes live.
        hold_d = (state_q != ST_IDLE);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            staged_q  <= '0;
            window_q  <= '0;
            hold_q    <= 1'b0;
            state_q   <= ST_IDLE;
            wr_out_q  <= '0;
            rd_out_q  <= '0;
`ifdef WINDOW_TIMEOUT_EN
            drain_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before the edge.
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            staged_q  <= staged_d;
            window_q  <= window_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            wr_out_q  <= wr_out_d;
            rd_out_q  <= rd_out_d;
`ifdef WINDOW_TIMEOUT_EN
            drain_cnt_q   <= drain_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign window_addr   = window_q;
    assign window_hold   = hold_q;

endmodule

// File: tb/tb_aximm_window_ctrl.sv
`timescale 1ns/1ps
// Testbench for aximm_window_ctrl: directed sequence with randomized data and
// monitor traffic, checked against a register/counter model of the window
// controller. Inputs are driven and outputs sampled on the falling clock edge.
module tb_aximm_window_ctrl;

    localparam int AW      = 64;
    localparam int ALIGN   = 12;
    localparam int MAX_OUT = 32;
    localparam int BOUND   = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [3:0]    S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [AW-1:0] window_addr;
    logic          window_hold;
    logic          mon_aw, mon_b, mon_ar, mon_rlast;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_stage;
    logic [63:0] m_win;
    int          m_wr, m_rd;
    bit          m_terr;

    aximm_window_ctrl #(.AW(AW), .ALIGN(ALIGN), .MAX_OUT(MAX_OUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .window_addr   (window_addr),
        .window_hold   (window_hold),
        .mon_aw        (mon_aw),
        .mon_b         (mon_b),
        .mon_ar        (mon_ar),
        .mon_rlast     (mon_rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Model: byte-merge into the staging register, then clear the sub-window bits.
    function automatic logic [63:0] merge(input logic [63:0] cur, input int word,
                                          input logic [31:0] d, input logic [3:0] s);
        logic [63:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[word*32 + b*8 +: 8] = d[b*8 +: 8];
        end
        return r & ~((64'd1 << ALIGN) - 64'd1);
    endfunction

    function automatic int cnt_step(input int c, input bit inc, input bit dec);
        if (inc && !dec) return (c < MAX_OUT) ? c + 1 : c;
        if (dec && !inc) return (c > 0) ? c - 1 : 0;
        return c;
    endfunction

    function automatic logic [31:0] exp_status(input bit busy);
        return (32'(m_rd) << 16) | (32'(m_wr) << 8) | (32'(m_terr) << 1) | 32'(busy);
    endfunction

    // Full AXI-Lite write; W may lag AW by a random number of cycles.
    // Returns on the falling edge where BVALID is first seen (BREADY is held high).
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        int wdly;
        bit w_pending, aw_fire, w_fire;
        n = 0;
        wdly = $urandom_range(0, 2);
        w_pending = (wdly != 0);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = !w_pending;
        while ((S_AXI_AWVALID || S_AXI_WVALID || w_pending) && n < BOUND) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge clk);
            n++;
            if (aw_fire) S_AXI_AWVALID = 1'b0;
            if (w_fire)  S_AXI_WVALID  = 1'b0;
            if (w_pending) begin
                wdly--;
                if (wdly == 0) begin
                    w_pending    = 1'b0;
                    S_AXI_WVALID = 1'b1;
                end
            end
        end
        while (!S_AXI_BVALID && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("write_completes", 64'(n < BOUND), 64'd1);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        resp = S_AXI_BRESP;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        bit fire;
        n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (S_AXI_ARVALID && n < BOUND) begin
            fire = S_AXI_ARVALID && S_AXI_ARREADY;
            @(negedge clk);
            n++;
            if (fire) S_AXI_ARVALID = 1'b0;
        end
        while (!S_AXI_RVALID && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("read_completes", 64'(n < BOUND), 64'd1);
        S_AXI_ARVALID = 1'b0;
        data = S_AXI_RDATA;
    endtask

    // One-cycle monitor pulse; the model counters follow the same pulse.
    task automatic pulse(input bit aw, input bit b, input bit ar, input bit rl);
        mon_aw    = aw;
        mon_b     = b;
        mon_ar    = ar;
        mon_rlast = rl;
        m_wr = cnt_step(m_wr, aw, b);
        m_rd = cnt_step(m_rd, ar, rl);
        @(negedge clk);
        mon_aw    = 1'b0;
        mon_b     = 1'b0;
        mon_ar    = 1'b0;
        mon_rlast = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit busy);
        logic [31:0] d;
        axi_read(4'hC, d);
        check(tag, 64'(d), 64'(exp_status(busy)));
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [31:0] r;
        logic [3:0]  s;
        int          word;
        int          cnt;
        int          kinds[$];

        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        mon_aw = 1'b0; mon_b = 1'b0; mon_ar = 1'b0; mon_rlast = 1'b0;
        m_stage = '0; m_win = '0; m_wr = 0; m_rd = 0; m_terr = 1'b0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_window_addr", 64'(window_addr), 64'd0);
        check("rst_window_hold", 64'(window_hold), 64'd0);
        check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
        check("rst_wready", 64'(S_AXI_WREADY), 64'd0);
        check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
        check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check("rst_bresp", 64'(S_AXI_BRESP), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stage a base and read it back with the sub-window bits cleared
        axi_write(4'h0, 32'h1234_5678, 4'hF, resp);
        m_stage = merge(m_stage, 0, 32'h1234_5678, 4'hF);
        check("stage_lo_bresp", 64'(resp), 64'd0);
        axi_write(4'h4, 32'h0000_0010, 4'hF, resp);
        m_stage = merge(m_stage, 1, 32'h0000_0010, 4'hF);
        check("stage_hi_bresp", 64'(resp), 64'd0);
        axi_read(4'h0, d);
        check("stage_lo_readback", 64'(d), 64'h1234_5000);
        check("rresp_okay", 64'(S_AXI_RRESP), 64'd0);
        axi_read(4'h4, d);
        check("stage_hi_readback", 64'(d), 64'h10);
        check("window_before_commit", 64'(window_addr), 64'd0);

        // Commit with nothing outstanding: hold for two cycles, base live two cycles after B
        axi_write(4'h8, 32'h1, 4'hF, resp);
        check("commit_bresp", 64'(resp), 64'd0);
        check("commit_hold_b_cycle", 64'(window_hold), 64'd0);
        @(negedge clk);
        check("commit_hold_c1", 64'(window_hold), 64'd1);
        check("commit_window_c1", 64'(window_addr), 64'd0);
        @(negedge clk);
        check("commit_hold_c2", 64'(window_hold), 64'd1);
        check("commit_window_c2", 64'(window_addr), 64'h10_1234_5000);
        m_win = m_stage;
        @(negedge clk);
        check("commit_hold_c3", 64'(window_hold), 64'd0);
        check_status("status_after_commit", 1'b0);

        // Random staging writes with random strobes
        for (int i = 0; i < 6; i++) begin
            word = $urandom_range(0, 1);
            r = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(4'(word * 4), r, s, resp);
            m_stage = merge(m_stage, word, r, s);
            check("rand_stage_bresp", 64'(resp), 64'd0);
            axi_read(4'h0, d);
            check("rand_stage_lo", 64'(d), 64'(m_stage[31:0]));
            axi_read(4'h4, d);
            check("rand_stage_hi", 64'(d), 64'(m_stage[63:32]));
        end
        axi_read(4'h8, d);
        check("ctrl_reads_zero", 64'(d), 64'd0);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, resp);
        check("status_write_okay", 64'(resp), 64'd0);
        check("window_unchanged_by_staging", 64'(window_addr), m_win);

        // Counter saturation, random traffic, then underflow clamp
        repeat (MAX_OUT + 3) pulse(1'b1, 1'b0, 1'b1, 1'b0);
        axi_read(4'hC, d);
        check("sat_wr_out", 64'(d[15:8]), 64'(MAX_OUT));
        check("sat_rd_out", 64'(d[23:16]), 64'(MAX_OUT));
        for (int i = 0; i < 60; i++) begin
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i % 15 == 14) check_status("rand_traffic_status", 1'b0);
        end
        repeat (MAX_OUT + 2) pulse(1'b0, 1'b1, 1'b0, 1'b1);
        check_status("underflow_clamp_status", 1'b0);

        // Commit with outstanding traffic: 3 writes and 2 reads in flight
        repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        r = $urandom;
        axi_write(4'h0, r, 4'hF, resp);
        m_stage = merge(m_stage, 0, r, 4'hF);
        r = $urandom;
        axi_write(4'h4, r, 4'hF, resp);
        m_stage = merge(m_stage, 1, r, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF, resp);
        check("drain_commit_bresp", 64'(resp), 64'd0);
        @(negedge clk);
        check("drain_hold_up", 64'(window_hold), 64'd1);
        axi_write(4'h0, ~m_stage[31:0], 4'hF, resp);
        check("busy_stage_slverr", 64'(resp), 64'h2);
        axi_read(4'h0, d);
        check("busy_stage_unchanged", 64'(d), 64'(m_stage[31:0]));
        axi_write(4'h8, 32'h1, 4'hF, resp);
        check("busy_ctrl_slverr", 64'(resp), 64'h2);
        check_status("drain_status_busy", 1'b1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_status("aw_b_same_cycle", 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check_status("ar_during_hold_counted", 1'b1);
        kinds.delete();
        for (int i = 0; i < m_wr; i++) kinds.push_back(0);
        for (int i = 0; i < m_rd; i++) kinds.push_back(1);
        for (int i = kinds.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = kinds[i];
            kinds[i] = kinds[j];
            kinds[j] = t;
        end
        foreach (kinds[i]) begin
            pulse(1'b0, kinds[i] == 0, 1'b0, kinds[i] == 1);
            check("drain_hold_kept", 64'(window_hold), 64'd1);
            check("drain_window_old", 64'(window_addr), m_win);
        end
        @(negedge clk);
        check("swap_window_new", 64'(window_addr), 64'(m_stage[AW-1:0]));
        check("swap_hold_still", 64'(window_hold), 64'd1);
        m_win = m_stage;
        @(negedge clk);
        check("swap_hold_release", 64'(window_hold), 64'd0);
        check_status("after_swap_status", 1'b0);

`ifdef WINDOW_TIMEOUT_EN
        // Drain that never completes: aborts, keeps the old base, sets the sticky flag
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        r = $urandom;
        axi_write(4'h0, r, 4'hF, resp);
        m_stage = merge(m_stage, 0, r, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF, resp);
        @(negedge clk);
        cnt = 0;
        while (window_hold && cnt < 70000) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_hold_length", 64'(cnt >= 65535 && cnt <= 65537), 64'd1);
        check("timeout_window_kept", 64'(window_addr), m_win);
        m_terr = 1'b1;
        check_status("timeout_status", 1'b0);
        axi_write(4'h8, 32'h2, 4'hF, resp);
        check("timeout_clear_bresp", 64'(resp), 64'd0);
        m_terr = 1'b0;
        check_status("timeout_cleared", 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Reset in the middle of a drain
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        axi_write(4'h0, 32'hFFFF_F000, 4'hF, resp);
        axi_write(4'h8, 32'h1, 4'hF, resp);
        @(negedge clk);
        check("pre_reset_hold", 64'(window_hold), 64'd1);
        reset = 1'b1;
        #1;
        check("midreset_window", 64'(window_addr), 64'd0);
        check("midreset_hold", 64'(window_hold), 64'd0);
        m_stage = '0; m_win = '0; m_wr = 0; m_rd = 0; m_terr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        axi_read(4'h0, d);
        check("midreset_stage_lost", 64'(d), 64'd0);
        check_status("midreset_status", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
